// File: rtl/data_island_scheduler.sv
// Data island scheduler: places preamble, guard bands and packet slots
// in horizontal blanking and strobes the packet picker once per packet.
module data_island_scheduler #(
    parameter int FRAME_WIDTH  = 858,
    parameter int SCREEN_WIDTH = 720,
    parameter int FRAME_HEIGHT = 525,
    parameter int MAX_PACKETS  = 18,
    parameter int BIT_WIDTH    = 12,
    parameter int BIT_HEIGHT   = 11
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    input  logic [BIT_WIDTH-1:0]  cx,
    input  logic [BIT_HEIGHT-1:0] cy,
    input  logic                  island_enable,
    output logic [1:0]            island_mode,
    output logic                  packet_enable,
    output logic [4:0]            packet_pixel_counter,
    output logic                  video_field_end
);

    localparam int ISLAND_START = SCREEN_WIDTH + 12;
    localparam int SLACK        = FRAME_WIDTH - SCREEN_WIDTH - 46;
    localparam int N_FIT        = (SLACK > 0) ? SLACK / 32 : 0;
    localparam int N            = (N_FIT < MAX_PACKETS) ? N_FIT : MAX_PACKETS;
    localparam int PW           = $clog2(MAX_PACKETS + 1);

    localparam logic [BIT_WIDTH-1:0]  CX_TRIG  = BIT_WIDTH'(ISLAND_START - 1);
    localparam logic [BIT_WIDTH-1:0]  CX_LAST  = BIT_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [BIT_HEIGHT-1:0] CY_LAST  = BIT_HEIGHT'(FRAME_HEIGHT - 1);
    localparam logic [PW-1:0]         PKT_LAST = PW'((N > 0) ? N - 1 : 0);
    localparam logic                  ISL_ON   = (N > 0);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_LGB  = 3'd2;
    localparam logic [2:0] S_PKT  = 3'd3;
    localparam logic [2:0] S_TGB  = 3'd4;

    localparam logic [1:0] M_CTL  = 2'b00;
    localparam logic [1:0] M_PRE  = 2'b01;
    localparam logic [1:0] M_GB   = 2'b10;
    localparam logic [1:0] M_DATA = 2'b11;

    logic [2:0]    state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [PW-1:0] pkt_q, pkt_d;
    logic [1:0]    mode_q, mode_d;
    logic          pe_q, pe_d;
    logic [4:0]    ppc_q, ppc_d;
    logic          vfe_q, vfe_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pkt_d   = pkt_q;
        // cx==0 while busy means the timing source resynced under us
        if (state_q != S_IDLE && cx == '0) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pkt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    pkt_d = '0;
                    if (cx == CX_TRIG && island_enable && ISL_ON)
                        state_d = S_PRE;
                end
                S_PRE: begin
                    if (cnt_q == 5'd7) begin
                        state_d = S_LGB;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                S_LGB: begin
                    if (cnt_q == 5'd1) begin
                        state_d = S_PKT;
                        cnt_d   = '0;
                        pkt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                S_PKT: begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        if (pkt_q == PKT_LAST) begin
                            state_d = S_TGB;
                            pkt_d   = '0;
                        end else begin
                            pkt_d = pkt_q + PW'(1);
                        end
                    end
                end
                S_TGB: begin
                    if (cnt_q == 5'd1) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    pkt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with cx
    always_comb begin
        mode_d = M_CTL;
        case (state_d)
            S_PRE:   mode_d = M_PRE;
            S_LGB:   mode_d = M_GB;
            S_PKT:   mode_d = M_DATA;
            S_TGB:   mode_d = M_GB;
            default: mode_d = M_CTL;
        endcase
        ppc_d = (state_d == S_PKT) ? cnt_d : 5'd0;
        pe_d  = (state_d == S_LGB && cnt_d == 5'd1) ||
                (state_d == S_PKT && cnt_d == 5'd31 && pkt_d != PKT_LAST);
        vfe_d = (cx == CX_LAST) && (cy == CY_LAST);
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pkt_q   <= '0;
            mode_q  <= M_CTL;
            pe_q    <= 1'b0;
            ppc_q   <= '0;
            vfe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pkt_q   <= pkt_d;
            mode_q  <= mode_d;
            pe_q    <= pe_d;
            ppc_q   <= ppc_d;
            vfe_q   <= vfe_d;
        end
    end

    assign island_mode          = mode_q;
    assign packet_enable        = pe_q;
    assign packet_pixel_counter = ppc_q;
    assign video_field_end      = vfe_q;

endmodule
